// File: rtl/riscv_mem_system_if.sv
// Fetch, data and program-loader signals between the core/loader side and the memory responder.
// Signal names follow the core's established port names.
interface riscv_mem_system_if;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [7:0]  MEM_addr;
  logic [31:0] MEM_wDATA;
  logic        dm_we;
  logic [31:0] MEM_rData;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [8:0]  ld_count;
  logic        ld_err;
  logic        core_rset;
  logic        run;

  modport master (
    output pc, MEM_addr, MEM_wDATA, dm_we, ld_valid, ld_data, ld_last,
    input  inst, MEM_rData, ld_ready, ld_count, ld_err, core_rset, run
  );

  modport slave (
    input  pc, MEM_addr, MEM_wDATA, dm_we, ld_valid, ld_data, ld_last,
    output inst, MEM_rData, ld_ready, ld_count, ld_err, core_rset, run
  );
endinterface

// File: rtl/riscv_mem_system.sv
// Memory responder for a single-cycle RISC-V core: IMEM filled by a valid/ready loader,
// then combinational fetch and DMEM access while the core runs.
module riscv_mem_system #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input logic               clk,
  input logic               rset,
  riscv_mem_system_if.slave bus
);

  localparam int unsigned IW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [8:0] IMEM_FULL = 9'(IMEM_DEPTH);
  localparam logic [8:0] IMEM_LAST = 9'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_e;

  state_e      state_q, state_d;
  logic [8:0]  ld_count_q, ld_count_d;
  logic        imem_we;

  logic [31:0] imem_mem [IMEM_DEPTH];
  logic [31:0] dmem_mem [DMEM_DEPTH];

  logic [IW-1:0] pc_idx;
  logic [DW-1:0] dm_idx;
  logic [IW-1:0] ld_idx;

  assign pc_idx = bus.pc[IW+1:2];
  assign dm_idx = bus.MEM_addr[DW-1:0];
  assign ld_idx = ld_count_q[IW-1:0];

  // Upper address bits are intentionally dropped so addresses wrap by truncation.
  logic unused_bits;
  assign unused_bits = ^{bus.pc, bus.MEM_addr};

  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      state_q    <= IDLE;
      ld_count_q <= 9'd0;
    end else begin
      state_q    <= state_d;
      ld_count_q <= ld_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    imem_we    = 1'b0;
    unique case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (bus.ld_valid) begin
          imem_we = 1'b1;
          if (ld_count_q != IMEM_FULL) begin
            ld_count_d = ld_count_q + 9'd1;
          end
          // ld_last wins when the final slot is also the final program word.
          if (bus.ld_last) begin
            state_d = RUN;
          end else if (ld_count_q == IMEM_LAST) begin
            state_d = ERR;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign bus.ld_ready  = (state_q == LOAD);
  assign bus.run       = (state_q == RUN);
  assign bus.core_rset = (state_q != RUN);
  assign bus.ld_err    = (state_q == ERR);
  assign bus.ld_count  = ld_count_q;

  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_mem[ld_idx] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.dm_we && (state_q == RUN)) begin
      dmem_mem[dm_idx] <= bus.MEM_wDATA;
    end
  end

  assign bus.inst = ((state_q == RUN) && (bus.pc[1:0] == 2'b00)) ? imem_mem[pc_idx] : NOP_INST;
  assign bus.MEM_rData = dmem_mem[dm_idx];

endmodule

// File: tb/tb_riscv_mem_system.sv
// Directed bench: a 256-word responder for load/fetch/DMEM/reset cases, a 4-word one for overflow.
module tb_riscv_mem_system;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W1  = 32'h00A0_0113;
  localparam logic [31:0] W2  = 32'h0020_81B3;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_inst;
  } fetch_vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;
  fetch_vec_t fv [8];

  always #5 clk = ~clk;

  riscv_mem_system_if ifa ();
  riscv_mem_system_if ifb ();

  riscv_mem_system #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .NOP_INST(NOP)) u_a (
    .clk(clk), .rset(rst_a), .bus(ifa.slave)
  );
  riscv_mem_system #(.IMEM_DEPTH(4), .DMEM_DEPTH(256), .NOP_INST(NOP)) u_b (
    .clk(clk), .rset(rst_b), .bus(ifb.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp_v);
    check(name, {31'd0, act}, {31'd0, exp_v});
  endtask

  task automatic checkc(input string name, input logic [8:0] act, input int exp_v);
    check(name, {23'd0, act}, 32'(exp_v));
  endtask

  // Offers one word and waits (bounded) for the edge that accepts it; returns at posedge+1.
  task automatic send(input bit to_b, input logic [31:0] d, input bit last);
    bit done;
    done = 1'b0;
    if (to_b) begin
      ifb.ld_valid = 1'b1; ifb.ld_data = d; ifb.ld_last = last;
    end else begin
      ifa.ld_valid = 1'b1; ifa.ld_data = d; ifa.ld_last = last;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (to_b ? ifb.ld_ready : ifa.ld_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    ifa.ld_valid = 1'b0; ifa.ld_last = 1'b0;
    ifb.ld_valid = 1'b0; ifb.ld_last = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ld_ready=0 for 20 cycles expected ld_ready=1 (data 0x%08h)", d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fv[0] = '{32'h0000_0000, W0};
    fv[1] = '{32'h0000_0004, W1};
    fv[2] = '{32'h0000_0008, W2};
    fv[3] = '{32'h0000_0002, NOP};
    fv[4] = '{32'h0000_0400, W0};
    fv[5] = '{32'h0000_0408, W2};
    fv[6] = '{32'h0000_0007, NOP};
    fv[7] = '{32'h0000_0404, W1};

    rst_a = 1'b1; rst_b = 1'b1;
    ifa.pc = '0; ifa.MEM_addr = '0; ifa.MEM_wDATA = '0; ifa.dm_we = 1'b0;
    ifa.ld_valid = 1'b0; ifa.ld_data = '0; ifa.ld_last = 1'b0;
    ifb.pc = '0; ifb.MEM_addr = '0; ifb.MEM_wDATA = '0; ifb.dm_we = 1'b0;
    ifb.ld_valid = 1'b0; ifb.ld_data = '0; ifb.ld_last = 1'b0;

    #12;
    checkb("rst_core_rset", ifa.core_rset, 1'b1);
    checkb("rst_run", ifa.run, 1'b0);
    checkb("rst_ld_ready", ifa.ld_ready, 1'b0);
    checkc("rst_ld_count", ifa.ld_count, 0);
    checkb("rst_ld_err", ifa.ld_err, 1'b0);

    @(negedge clk); rst_a = 1'b0;
    @(posedge clk); #1;
    checkb("load_ld_ready", ifa.ld_ready, 1'b1);
    checkb("load_core_rset", ifa.core_rset, 1'b1);
    ifa.pc = 32'h0; #1;
    check("load_fetch_nop", ifa.inst, NOP);

    // T1: three-word program
    send(1'b0, W0, 1'b0);
    checkc("t1_count1", ifa.ld_count, 1);
    send(1'b0, W1, 1'b0);
    checkc("t1_count2", ifa.ld_count, 2);
    checkb("t1_run_before_last", ifa.run, 1'b0);
    send(1'b0, W2, 1'b1);
    checkc("t1_count3", ifa.ld_count, 3);
    checkb("t1_run", ifa.run, 1'b1);
    checkb("t1_core_rset", ifa.core_rset, 1'b0);
    checkb("t1_ld_ready", ifa.ld_ready, 1'b0);

    // T2: fetch table
    for (int i = 0; i < 8; i++) begin
      ifa.pc = fv[i].pc;
      @(negedge clk);
      check($sformatf("t2_fetch_pc_%08h", fv[i].pc), ifa.inst, fv[i].exp_inst);
    end

    // Loader activity in RUN must not disturb IMEM or the count
    @(posedge clk); #1;
    ifa.ld_valid = 1'b1; ifa.ld_data = 32'hFFFF_FFFF; ifa.ld_last = 1'b1;
    @(posedge clk); #1;
    ifa.ld_valid = 1'b0; ifa.ld_last = 1'b0;
    ifa.pc = 32'h0; #1;
    checkc("run_ignore_ld_count", ifa.ld_count, 3);
    check("run_ignore_ld_inst", ifa.inst, W0);

    // Seed DMEM[0x10] with a known value
    ifa.dm_we = 1'b1; ifa.MEM_addr = 8'h10; ifa.MEM_wDATA = 32'h1111_1111;
    @(posedge clk); #1;
    ifa.dm_we = 1'b0; #1;
    check("dm_seed", ifa.MEM_rData, 32'h1111_1111);

    // Async reset out of RUN, then stores must be blocked during LOAD
    #1 rst_a = 1'b1;
    #1;
    checkb("rst_run_core_rset", ifa.core_rset, 1'b1);
    checkc("rst_run_count", ifa.ld_count, 0);
    @(negedge clk); rst_a = 1'b0;
    @(posedge clk); #1;
    ifa.dm_we = 1'b1; ifa.MEM_addr = 8'h10; ifa.MEM_wDATA = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifa.dm_we = 1'b0; #1;
    check("t3_dm_blocked_load", ifa.MEM_rData, 32'h1111_1111);

    // T4: backpressure via ld_valid 1,0,1
    checkb("t4_ready", ifa.ld_ready, 1'b1);
    ifa.ld_valid = 1'b1; ifa.ld_data = W0; ifa.ld_last = 1'b0;
    @(posedge clk); #1;
    checkc("t4_count_a", ifa.ld_count, 1);
    ifa.ld_valid = 1'b0; ifa.ld_data = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    checkc("t4_count_b", ifa.ld_count, 1);
    ifa.ld_valid = 1'b1; ifa.ld_data = W1; ifa.ld_last = 1'b1;
    @(posedge clk); #1;
    ifa.ld_valid = 1'b0; ifa.ld_last = 1'b0;
    checkc("t4_count_c", ifa.ld_count, 2);
    checkb("t4_run", ifa.run, 1'b1);
    ifa.pc = 32'h0; #1; check("t4_fetch0", ifa.inst, W0);
    ifa.pc = 32'h4; #1; check("t4_fetch1", ifa.inst, W1);
    ifa.pc = 32'h8; #1; check("t4_fetch2_kept", ifa.inst, W2);

    // T3: read-during-write in RUN
    @(posedge clk); #1;
    ifa.dm_we = 1'b1; ifa.MEM_addr = 8'h10; ifa.MEM_wDATA = 32'hDEAD_BEEF; #1;
    check("t3_rdw_old", ifa.MEM_rData, 32'h1111_1111);
    @(posedge clk); #1;
    ifa.dm_we = 1'b0; #1;
    check("t3_rdw_new", ifa.MEM_rData, 32'hDEAD_BEEF);

    // T6: async reset mid-load, then a one-word reload
    #1 rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    @(posedge clk); #1;
    send(1'b0, 32'hAAAA_0001, 1'b0);
    send(1'b0, 32'hAAAA_0002, 1'b0);
    checkc("t6_count_pre", ifa.ld_count, 2);
    #2 rst_a = 1'b1;
    #1;
    checkc("t6_count_rst", ifa.ld_count, 0);
    checkb("t6_core_rset", ifa.core_rset, 1'b1);
    checkb("t6_ld_ready_idle", ifa.ld_ready, 1'b0);
    @(negedge clk); rst_a = 1'b0;
    @(posedge clk); #1;
    send(1'b0, 32'h0010_0093, 1'b1);
    checkb("t6_run", ifa.run, 1'b1);
    checkc("t6_count", ifa.ld_count, 1);
    ifa.pc = 32'h0; #1; check("t6_fetch0", ifa.inst, 32'h0010_0093);
    ifa.pc = 32'h4; #1; check("t6_fetch1_kept", ifa.inst, 32'hAAAA_0002);

    // T5: overflow on the 4-word instance
    @(negedge clk); rst_b = 1'b0;
    @(posedge clk); #1;
    send(1'b1, 32'hB000_0000, 1'b0);
    send(1'b1, 32'hB000_0001, 1'b0);
    send(1'b1, 32'hB000_0002, 1'b0);
    checkb("t5_err_before", ifb.ld_err, 1'b0);
    send(1'b1, 32'hB000_0003, 1'b0);
    checkb("t5_err", ifb.ld_err, 1'b1);
    checkb("t5_ready", ifb.ld_ready, 1'b0);
    checkb("t5_core_rset", ifb.core_rset, 1'b1);
    checkb("t5_run", ifb.run, 1'b0);
    checkc("t5_count", ifb.ld_count, 4);
    for (int i = 0; i < 3; i++) begin
      ifb.ld_valid = 1'b1; ifb.ld_data = 32'hC0DE_0000 + 32'(i);
      @(posedge clk); #1;
    end
    ifb.ld_valid = 1'b0;
    checkc("t5_extra_count", ifb.ld_count, 4);
    checkb("t5_extra_err", ifb.ld_err, 1'b1);
    ifb.pc = 32'h0; #1; check("t5_fetch_nop", ifb.inst, NOP);

    // Final slot carrying ld_last goes to RUN; fetch wraps at depth 4
    #1 rst_b = 1'b1;
    @(negedge clk); rst_b = 1'b0;
    @(posedge clk); #1;
    send(1'b1, 32'hC000_0000, 1'b0);
    send(1'b1, 32'hC000_0001, 1'b0);
    send(1'b1, 32'hC000_0002, 1'b0);
    send(1'b1, 32'hC000_0003, 1'b1);
    checkb("full_last_run", ifb.run, 1'b1);
    checkb("full_last_err", ifb.ld_err, 1'b0);
    checkc("full_last_count", ifb.ld_count, 4);
    ifb.pc = 32'h10; #1; check("wrap4_fetch_0x10", ifb.inst, 32'hC000_0000);
    ifb.pc = 32'h0C; #1; check("wrap4_fetch_0x0c", ifb.inst, 32'hC000_0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
